lsu_issue_scheduler: RTL and testbench
======================================

// Module: lsu_issue_scheduler
// PURPOSE
//  Small in-order issue window between decode (ID) and the issue stage.
//  Normally issues the oldest entry. When the oldest entry is a LOAD/STORE
//  and the LSU is busy, it may issue the next younger, independent ALU-class
//  entry instead. A deferral counter bounds how long the memory op can be
//  bypassed.
// PARAMETERS
//  NR_ENTRIES  2  window depth; legal range 2..4; only slot 1 may bypass slot 0
//  MAX_DEFER   4  max consecutive bypasses of one head entry; legal range 1..15
// PORTS
//  clk_i                 in   1      clock
//  rst_ni                in   1      reset: synchronous, active-low
//  flush_i               in   1      pipeline flush
//  debug_req_i           in   1      debug request; disables bypass
//  issue_entry_i         in   SBE    decoded entry (ariane_pkg::scoreboard_entry_t)
//  issue_entry_valid_i   in   1      issue_entry_i is valid
//  is_ctrl_flow_i        in   1      entry is control flow
//  issue_instr_ack_o     out  1      entry accepted this cycle
//  issue_entry_o         out  SBE    selected entry
//  issue_entry_valid_o   out  1      issue_entry_o is valid
//  is_ctrl_flow_o        out  1      control-flow flag of the selected entry
//  issue_instr_ack_i     in   1      issue stage consumed issue_entry_o
//  lsu_ready_i           in   1      LSU can accept an op
//  bypass_o              out  1      selected entry is slot 1 (perf pulse)
//  defer_cnt_o           out  4      current deferral count
// BEHAVIOUR
//  - Storage: slots 0..NR_ENTRIES-1 hold {sbe, is_ctrl_flow, valid}, compacted
//    with slot 0 as the oldest.
//  - Reset values (rst_ni=0 at clk edge): all slots invalid, defer_cnt=0.
//    Reset takes priority over flush and push.
//    Outputs after reset: valid_o=0, ack_o=1, bypass_o=0, defer_cnt_o=0,
//    entry_o/ctrl_flow_o='0.
//  - Push: ack_o = !full & !flush_i. This is registered state only, with no
//    combinational path from valid_i or ack_i.
//    A push fires when valid_i & ack_o. The new entry is written to the first
//    free slot after this cycle's pop. Latency from push to output = 1 cycle.
//  - bypass condition (combinational), all of the following:
//    - slot0.valid & slot1.valid
//    - slot0.fu in {LOAD, STORE}
//    - !lsu_ready_i
//    - !debug_req_i
//    - defer_cnt < MAX_DEFER
//    - slot1.fu not in {LOAD, STORE, CTRL_FLOW, MULT, CSR}
//    - !slot0.ex.valid & !slot1.ex.valid
//    - no hazard: slot1.rs1/rs2 != slot0.rd; slot1.rd != slot0.rs1/rs2/rd.
//      Raw 5-bit field compare; x0 counts as a conflict.
//  - Select: bypass ? slot1 : slot0. valid_o = selected slot valid & !flush_i.
//    bypass_o = bypass & valid_o.
//  - Pop: fires when valid_o & ack_i.
//    - Pop of slot0: shift slots 1.. down by one.
//    - Pop of slot1: shift slots 2.. down by one; slot0 is kept.
//  - defer_cnt:
//    - +1 on a bypass pop, saturating at MAX_DEFER.
//    - Cleared to 0 on a slot0 pop, a flush, or a reset.
//    - Holds otherwise.
//    At MAX_DEFER, slot0 must issue before any further bypass.
//  - Simultaneous push and pop when full: not allowed (ack_o=0 when full).
//    Push and pop in the same cycle when not full: pop is applied first, then
//    push to the new tail.
//  - Flush: ack_o=0 and valid_o=0 in that cycle. Next cycle all slots are
//    invalid and defer_cnt=0. Any push or pop in the flush cycle is ignored.
//  - Reset mid-operation: same end state as a flush, plus outputs at their
//    reset values.
//  - Ordering: ID-order commit is preserved by the scoreboard trans_id. This
//    block changes only issue order, never trans_id.
// STRUCTURE
//  - ariane_pkg additions:
//    - function is_mem_fu(fu_t)
//    - function is_bypassable_fu(fu_t)
//    - localparam DEFER_CNT_W = 4
//  - Sub-module issue_hazard_check: purely combinational. Inputs: older sbe,
//    younger sbe. Output: hazard_o. Reusable by a later wider window.
//  - Rest of the block: the slot array, the pop/push compaction logic, and
//    defer_cnt.
// TESTING
//  - Reset: rst_ni=0 for 2 cycles with valid_i=1 -> valid_o=0, ack_o=1,
//    defer_cnt_o=0; first push lands at output 1 cycle after release.
//  - Bypass: slot0=LOAD rd=x5, slot1=ALU rs1=x6 rd=x7, lsu_ready_i=0, ack_i=1
//    -> ALU issues, bypass_o=1, defer_cnt_o=1, LOAD stays in slot0.
//  - Hazard: slot1=ALU rs1=x5, slot0=LOAD rd=x5, lsu_ready_i=0 -> LOAD
//    presented, bypass_o=0.
//  - Starvation: MAX_DEFER=2, LOAD head, 3 independent ALU ops, LSU busy ->
//    2 ALU ops bypass, then LOAD presented; defer_cnt_o 0->1->2->0 after the
//    LOAD pops.
//  - Flush while full with defer_cnt=3 -> ack_o=0 and valid_o=0 that cycle;
//    next cycle empty, defer_cnt_o=0, ack_o=1.
//  - Push and pop same cycle with 1 entry, ack_i=1, valid_i=1 -> occupancy
//    stays 1 and the new entry is presented next cycle, in order.

Source files
------------

// File: rtl/lsu_issue_scheduler_pkg.sv
// Shared types for the LSU-aware issue window: functional-unit classes,
// the decoded scoreboard entry and the window slot layout.
package lsu_issue_scheduler_pkg;

    localparam int unsigned DEFER_CNT_W = 4;

    typedef enum logic [3:0] {
        NONE      = 4'd0,
        LOAD      = 4'd1,
        STORE     = 4'd2,
        ALU       = 4'd3,
        CTRL_FLOW = 4'd4,
        MULT      = 4'd5,
        CSR       = 4'd6,
        FPU       = 4'd7
    } fu_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } exception_t;

    typedef struct packed {
        logic [2:0] trans_id;
        fu_t        fu;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        exception_t ex;
    } scoreboard_entry_t;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
        logic              valid;
    } slot_t;

    function automatic logic is_mem_fu(fu_t fu);
        return (fu == LOAD) || (fu == STORE);
    endfunction

    // Only plain single-cycle-class units may overtake a stalled memory op.
    function automatic logic is_bypassable_fu(fu_t fu);
        return !((fu == LOAD) || (fu == STORE) || (fu == CTRL_FLOW) ||
                 (fu == MULT) || (fu == CSR));
    endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Register dependency check between an older and a younger entry.
// Raw 5-bit compares: x0 is deliberately treated as a real register.
module issue_hazard_check
    import lsu_issue_scheduler_pkg::*;
(
    input  scoreboard_entry_t older_i,
    input  scoreboard_entry_t younger_i,
    output logic              hazard_o
);

    logic raw_hazard;
    logic war_waw_hazard;
    logic unused_fields;

    assign raw_hazard     = (younger_i.rs1 == older_i.rd) || (younger_i.rs2 == older_i.rd);
    assign war_waw_hazard = (younger_i.rd == older_i.rs1) || (younger_i.rd == older_i.rs2) ||
                            (younger_i.rd == older_i.rd);
    assign hazard_o       = raw_hazard || war_waw_hazard;

    assign unused_fields  = ^{older_i.trans_id, older_i.fu, older_i.ex,
                              younger_i.trans_id, younger_i.fu, younger_i.ex};

endmodule

// File: rtl/lsu_issue_scheduler.sv
// In-order issue window that lets slot 1 overtake a memory op in slot 0
// while the LSU is busy, bounded by a per-head deferral counter.
module lsu_issue_scheduler
    import lsu_issue_scheduler_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 2,
    parameter int unsigned MAX_DEFER  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   debug_req_i,
    input  scoreboard_entry_t      issue_entry_i,
    input  logic                   issue_entry_valid_i,
    input  logic                   is_ctrl_flow_i,
    output logic                   issue_instr_ack_o,
    output scoreboard_entry_t      issue_entry_o,
    output logic                   issue_entry_valid_o,
    output logic                   is_ctrl_flow_o,
    input  logic                   issue_instr_ack_i,
    input  logic                   lsu_ready_i,
    output logic                   bypass_o,
    output logic [DEFER_CNT_W-1:0] defer_cnt_o
);

    localparam logic [DEFER_CNT_W-1:0] MAX_DEFER_C = DEFER_CNT_W'(MAX_DEFER);

    // Handshakes: a transfer happens on a cycle where valid and ack are both
    // high. Upstream ack depends only on occupancy and flush_i, never on
    // issue_entry_valid_i or issue_instr_ack_i.
    slot_t                   slots_q [NR_ENTRIES];
    slot_t                   slots_d [NR_ENTRIES];
    logic [DEFER_CNT_W-1:0]  defer_cnt_q, defer_cnt_d;

    logic  full;
    logic  hazard;
    logic  bypass;
    logic  push;
    logic  pop;
    logic  placed;
    slot_t sel_slot;

    always_comb begin
        full = 1'b1;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            full = full & slots_q[i].valid;
        end
    end

    issue_hazard_check u_hazard (
        .older_i   (slots_q[0].sbe),
        .younger_i (slots_q[1].sbe),
        .hazard_o  (hazard)
    );

    assign bypass = slots_q[0].valid && slots_q[1].valid &&
                    is_mem_fu(slots_q[0].sbe.fu) &&
                    !lsu_ready_i && !debug_req_i &&
                    (defer_cnt_q < MAX_DEFER_C) &&
                    is_bypassable_fu(slots_q[1].sbe.fu) &&
                    !slots_q[0].sbe.ex.valid && !slots_q[1].sbe.ex.valid &&
                    !hazard;

    assign sel_slot            = bypass ? slots_q[1] : slots_q[0];
    assign issue_entry_o       = sel_slot.sbe;
    assign is_ctrl_flow_o      = sel_slot.is_ctrl_flow;
    assign issue_entry_valid_o = sel_slot.valid && !flush_i;
    assign bypass_o            = bypass && issue_entry_valid_o;
    assign issue_instr_ack_o   = !full && !flush_i;
    assign defer_cnt_o         = defer_cnt_q;

    assign pop  = issue_entry_valid_o && issue_instr_ack_i;
    assign push = issue_entry_valid_i && issue_instr_ack_o;

    always_comb begin
        slots_d     = slots_q;
        defer_cnt_d = defer_cnt_q;
        placed      = 1'b0;
        if (flush_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                slots_d[i] = '0;
            end
            defer_cnt_d = '0;
        end else begin
            if (pop) begin
                // A bypass pop removes slot 1 and leaves the head in place.
                for (int i = 0; i < NR_ENTRIES - 1; i++) begin
                    if ((i != 0) || !bypass) begin
                        slots_d[i] = slots_q[i+1];
                    end
                end
                slots_d[NR_ENTRIES-1] = '0;
                if (bypass) begin
                    defer_cnt_d = (defer_cnt_q == MAX_DEFER_C) ? defer_cnt_q
                                                               : defer_cnt_q + 1'b1;
                end else begin
                    defer_cnt_d = '0;
                end
            end
            if (push) begin
                for (int i = 0; i < NR_ENTRIES; i++) begin
                    if (!placed && !slots_d[i].valid) begin
                        slots_d[i].sbe          = issue_entry_i;
                        slots_d[i].is_ctrl_flow = is_ctrl_flow_i;
                        slots_d[i].valid        = 1'b1;
                        placed                  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                slots_q[i] <= '0;
            end
            defer_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                slots_q[i] <= slots_d[i];
            end
            defer_cnt_q <= defer_cnt_d;
        end
    end

endmodule

// File: tb/tb_lsu_issue_scheduler.sv
// Bench for lsu_issue_scheduler: two configurations driven in lockstep and
// compared every cycle against a queue-style reference of the issue window.
module tb_lsu_issue_scheduler;
    import lsu_issue_scheduler_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              debug_req;
    scoreboard_entry_t entry_i;
    logic              valid_i;
    logic              cf_i;
    logic              ack_i;
    logic              lsu_ready;

    logic              ack_o   [2];
    scoreboard_entry_t ent_o   [2];
    logic              valid_o [2];
    logic              cf_o    [2];
    logic              byp_o   [2];
    logic [3:0]        defer_o [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        scoreboard_entry_t sbe;
        logic              cf;
    } ment_t;

    ment_t mslot [2][4];
    int    mcnt  [2];
    int    mdef  [2];
    int    mdep  [2];
    int    mmax  [2];

    lsu_issue_scheduler #(.NR_ENTRIES(2), .MAX_DEFER(4)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_req_i(debug_req),
        .issue_entry_i(entry_i), .issue_entry_valid_i(valid_i), .is_ctrl_flow_i(cf_i),
        .issue_instr_ack_o(ack_o[0]), .issue_entry_o(ent_o[0]),
        .issue_entry_valid_o(valid_o[0]), .is_ctrl_flow_o(cf_o[0]),
        .issue_instr_ack_i(ack_i), .lsu_ready_i(lsu_ready),
        .bypass_o(byp_o[0]), .defer_cnt_o(defer_o[0])
    );

    lsu_issue_scheduler #(.NR_ENTRIES(3), .MAX_DEFER(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_req_i(debug_req),
        .issue_entry_i(entry_i), .issue_entry_valid_i(valid_i), .is_ctrl_flow_i(cf_i),
        .issue_instr_ack_o(ack_o[1]), .issue_entry_o(ent_o[1]),
        .issue_entry_valid_o(valid_o[1]), .is_ctrl_flow_o(cf_o[1]),
        .issue_instr_ack_i(ack_i), .lsu_ready_i(lsu_ready),
        .bypass_o(byp_o[1]), .defer_cnt_o(defer_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic scoreboard_entry_t mk(input fu_t fu, input int rs1, input int rs2,
                                             input int rd, input int tid);
        scoreboard_entry_t e;
        e          = '0;
        e.fu       = fu;
        e.rs1      = 5'(rs1);
        e.rs2      = 5'(rs2);
        e.rd       = 5'(rd);
        e.trans_id = 3'(tid);
        return e;
    endfunction

    // Slot 1 may go ahead of a stalled memory head when it is a plain op,
    // shares no register with the head, nothing raised an exception and the
    // head has not yet been passed the maximum number of times.
    function automatic logic m_bypass(input int d);
        scoreboard_entry_t o, y;
        if (mcnt[d] < 2) return 1'b0;
        o = mslot[d][0].sbe;
        y = mslot[d][1].sbe;
        if (!(o.fu == LOAD || o.fu == STORE)) return 1'b0;
        if (lsu_ready || debug_req) return 1'b0;
        if (mdef[d] >= mmax[d]) return 1'b0;
        if (y.fu == LOAD || y.fu == STORE || y.fu == CTRL_FLOW || y.fu == MULT || y.fu == CSR)
            return 1'b0;
        if (o.ex.valid || y.ex.valid) return 1'b0;
        if (y.rs1 == o.rd || y.rs2 == o.rd || y.rd == o.rs1 || y.rd == o.rs2 || y.rd == o.rd)
            return 1'b0;
        return 1'b1;
    endfunction

    task automatic cycle(input bit do_chk);
        logic eb [2];
        logic ev [2];
        logic ea [2];
        int   sel;
        string nm;
        #1;
        for (int d = 0; d < 2; d++) begin
            nm    = (d == 0) ? "a" : "b";
            ea[d] = (mcnt[d] < mdep[d]) && !flush;
            ev[d] = (mcnt[d] > 0) && !flush;
            eb[d] = m_bypass(d);
            if (do_chk) begin
                chk({nm, "_ack"},    32'(ack_o[d]),   32'(ea[d]));
                chk({nm, "_valid"},  32'(valid_o[d]), 32'(ev[d]));
                chk({nm, "_bypass"}, 32'(byp_o[d]),   32'(eb[d] && ev[d]));
                chk({nm, "_defer"},  32'(defer_o[d]), 32'(mdef[d]));
                if (ev[d]) begin
                    sel = eb[d] ? 1 : 0;
                    chk({nm, "_entry"}, 32'(ent_o[d]), 32'(mslot[d][sel].sbe));
                    chk({nm, "_cf"},    32'(cf_o[d]),  32'(mslot[d][sel].cf));
                end
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n || flush) begin
                mcnt[d] = 0;
                mdef[d] = 0;
            end else begin
                if (ev[d] && ack_i) begin
                    sel = eb[d] ? 1 : 0;
                    for (int k = sel; k < mcnt[d] - 1; k++) mslot[d][k] = mslot[d][k+1];
                    mcnt[d]--;
                    mdef[d] = eb[d] ? ((mdef[d] + 1 > mmax[d]) ? mmax[d] : mdef[d] + 1) : 0;
                end
                if (valid_i && ea[d]) begin
                    mslot[d][mcnt[d]].sbe = entry_i;
                    mslot[d][mcnt[d]].cf  = cf_i;
                    mcnt[d]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        valid_i   = 1'b0;
        ack_i     = 1'b1;
        lsu_ready = 1'b1;
        repeat (n) cycle(1);
        ack_i     = 1'b0;
    endtask

    scoreboard_entry_t e_ld;
    scoreboard_entry_t e_alu;

    initial begin
        mdep = '{2, 3};
        mmax = '{4, 2};
        mcnt = '{0, 0};
        mdef = '{0, 0};
        rst_n = 1'b0; flush = 1'b0; debug_req = 1'b0; cf_i = 1'b0;
        ack_i = 1'b0; lsu_ready = 1'b1; valid_i = 1'b1;
        entry_i = mk(ALU, 1, 2, 3, 1);
        @(negedge clk);

        // Reset held two cycles with a pending push
        cycle(0);
        cycle(0);
        rst_n = 1'b1;
        #1;
        chk("rst_valid",  32'(valid_o[0]), 32'd0);
        chk("rst_ack",    32'(ack_o[0]),   32'd1);
        chk("rst_defer",  32'(defer_o[0]), 32'd0);
        chk("rst_bypass", 32'(byp_o[0]),   32'd0);
        chk("rst_entry",  32'(ent_o[0]),   32'd0);
        chk("rst_cf",     32'(cf_o[0]),    32'd0);
        cycle(1);
        valid_i = 1'b0;
        #1;
        chk("first_push_valid", 32'(valid_o[0]), 32'd1);
        chk("first_push_entry", 32'(ent_o[0]),   32'(entry_i));
        drain(2);

        // Independent ALU overtakes a LOAD while the LSU is busy
        e_ld      = mk(LOAD, 1, 2, 5, 2);
        lsu_ready = 1'b0;
        valid_i   = 1'b1; entry_i = e_ld;               cycle(1);
        e_alu     = mk(ALU, 6, 8, 7, 3);
        entry_i   = e_alu;                              cycle(1);
        valid_i   = 1'b0; ack_i = 1'b1;
        #1;
        chk("byp_pulse", 32'(byp_o[0]),  32'd1);
        chk("byp_entry", 32'(ent_o[0]),  32'(e_alu));
        cycle(1);
        ack_i = 1'b0;
        #1;
        chk("byp_defer", 32'(defer_o[0]), 32'd1);
        chk("byp_head",  32'(ent_o[0]),   32'(e_ld));

        // Younger op reads the LOAD destination: no bypass
        valid_i = 1'b1; entry_i = mk(ALU, 5, 3, 9, 4);  cycle(1);
        valid_i = 1'b0;
        #1;
        chk("haz_bypass", 32'(byp_o[0]), 32'd0);
        chk("haz_head",   32'(ent_o[0]), 32'(e_ld));
        cycle(1);
        drain(4);

        // Deferral bound on the MAX_DEFER=2 instance
        lsu_ready = 1'b0;
        valid_i = 1'b1; entry_i = e_ld;                 cycle(1);
        entry_i = mk(ALU, 6, 8, 10, 5);                 cycle(1);
        #1;
        chk("starve_d0", 32'(defer_o[1]), 32'd0);
        ack_i = 1'b1; entry_i = mk(ALU, 6, 8, 11, 6);   cycle(1);
        #1;
        chk("starve_d1", 32'(defer_o[1]), 32'd1);
        entry_i = mk(ALU, 6, 8, 12, 7);                 cycle(1);
        valid_i = 1'b0;
        #1;
        chk("starve_d2",     32'(defer_o[1]), 32'd2);
        chk("starve_nobyp",  32'(byp_o[1]),   32'd0);
        chk("starve_head",   32'(ent_o[1]),   32'(e_ld));
        cycle(1);
        #1;
        chk("starve_clr", 32'(defer_o[1]), 32'd0);
        drain(5);

        // Build defer_cnt=3 on the MAX_DEFER=4 instance, fill it, then flush
        lsu_ready = 1'b0;
        valid_i = 1'b1; ack_i = 1'b0; entry_i = e_ld;   cycle(1);
        for (int r = 0; r < 3; r++) begin
            valid_i = 1'b1; ack_i = 1'b0; entry_i = mk(ALU, 6, 8, 10 + r, r); cycle(1);
            valid_i = 1'b0; ack_i = 1'b1;                                     cycle(1);
        end
        valid_i = 1'b1; ack_i = 1'b0; entry_i = mk(ALU, 6, 8, 14, 3);         cycle(1);
        flush = 1'b1; ack_i = 1'b1;
        #1;
        chk("flush_ack",   32'(ack_o[0]),   32'd0);
        chk("flush_valid", 32'(valid_o[0]), 32'd0);
        chk("flush_defer", 32'(defer_o[0]), 32'd3);
        cycle(1);
        flush = 1'b0; valid_i = 1'b0; ack_i = 1'b0;
        #1;
        chk("post_flush_valid", 32'(valid_o[0]), 32'd0);
        chk("post_flush_ack",   32'(ack_o[0]),   32'd1);
        chk("post_flush_defer", 32'(defer_o[0]), 32'd0);

        // Push and pop together with a single resident entry
        lsu_ready = 1'b1;
        valid_i = 1'b1; entry_i = mk(ALU, 1, 1, 1, 1);  cycle(1);
        e_alu = entry_i;
        ack_i = 1'b1; entry_i = mk(FPU, 2, 2, 2, 2);
        #1;
        chk("pp_first", 32'(ent_o[0]), 32'(e_alu));
        cycle(1);
        e_alu = entry_i;
        valid_i = 1'b0; ack_i = 1'b0;
        #1;
        chk("pp_second",  32'(ent_o[0]),   32'(e_alu));
        chk("pp_occ_ack", 32'(ack_o[0]),   32'd1);
        drain(2);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            debug_req = ($urandom_range(0, 9) == 0);
            lsu_ready = ($urandom_range(0, 2) == 0);
            valid_i   = ($urandom_range(0, 9) < 7);
            ack_i     = ($urandom_range(0, 9) < 6);
            cf_i      = 1'(($urandom_range(0, 1)));
            entry_i   = mk(fu_t'($urandom_range(0, 7)), $urandom_range(0, 7),
                           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            entry_i.ex.valid = ($urandom_range(0, 15) == 0);
            entry_i.ex.cause = 4'($urandom_range(0, 15));
            cycle(1);
        end
        rst_n = 1'b1; flush = 1'b0; debug_req = 1'b0;
        drain(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
